// File: rtl/link_pkg.sv
// Shared types and defaults for the downstream link SIPO.
package link_pkg;

    // Assembler state: waiting for the low half or the high half of a packet.
    typedef enum logic {S_LO, S_HI} asm_state_e;

    localparam int LINK_HALF_WIDTH       = 32;
    localparam int LINK_FIFO_DEPTH       = 4;
    localparam int LINK_TOKEN_DECIMATION = 4;
    localparam int LINK_CNT_WIDTH        = 7;

    // Index width for a power-of-two depth. Returns at least 1 so that a
    // depth of 1 (e.g. a decimation of 1) still yields a legal vector.
    function automatic int ptr_width(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/link_sipo_fifo.sv
// Synchronous FIFO with a registered head. The head is read straight from
// the storage registers, so a pushed word is visible the cycle after the push.
module link_sipo_fifo
    import link_pkg::*;
#(
    parameter int WIDTH = 2 * LINK_HALF_WIDTH,
    parameter int DEPTH = LINK_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = ptr_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW:0]      wr_q, rd_q;
    logic             do_push, do_pop;

    // The extra wrap bit separates full (wrap bits differ) from empty.
    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign do_pop  = pop_i & ~empty_o;
    // A push into a full FIFO is accepted only if a pop frees the slot.
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = mem_q[rd_q[PW-1:0]];

    // Storage and pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q[PW-1:0]] <= data_i;
                wr_q                <= wr_q + (PW+1)'(1);
            end
            if (do_pop) rd_q <= rd_q + (PW+1)'(1);
        end
    end

endmodule

// File: rtl/link_downstream_sipo.sv
// Receive-side SIPO: pairs io half-words into core words, buffers them and
// returns credits upstream by toggling io_token_o.
// Optional macro LINK_SIPO_ERR_CHK_EN enables the sticky error_o flag.
module link_downstream_sipo
    import link_pkg::*;
#(
    parameter int HALF_WIDTH       = LINK_HALF_WIDTH,
    parameter int FIFO_DEPTH       = LINK_FIFO_DEPTH,
    parameter int TOKEN_DECIMATION = LINK_TOKEN_DECIMATION,
    parameter int CNT_WIDTH        = LINK_CNT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    io_valid_i,
    input  logic [HALF_WIDTH-1:0]   io_data_i,
    output logic                    core_valid_o,
    output logic [2*HALF_WIDTH-1:0] core_data_o,
    input  logic                    core_yumi_i,
    output logic                    io_token_o,
    output logic [CNT_WIDTH-1:0]    credits_returned_o,
    output logic                    error_o
);

    localparam int DW = ptr_width(TOKEN_DECIMATION);

    asm_state_e            state_q, state_d;
    logic [HALF_WIDTH-1:0] lo_q, lo_d;
    logic [DW-1:0]         dec_q, dec_d;
    logic                  token_q, token_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  push, pop, full, empty;

    assign push = (state_q == S_HI) & io_valid_i;
    assign pop  = core_yumi_i & core_valid_o;

    link_sipo_fifo #(.WIDTH(2*HALF_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  ({io_data_i, lo_q}),
        .pop_i   (pop),
        .data_o  (core_data_o),
        .full_o  (full),
        .empty_o (empty)
    );

    assign core_valid_o       = ~empty;
    assign io_token_o         = token_q;
    assign credits_returned_o = cnt_q;

    // Assembler, decimation counter and credit bookkeeping next-state.
    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        dec_d   = dec_q;
        token_d = token_q;
        cnt_d   = cnt_q;
        if (io_valid_i) begin
            if (state_q == S_LO) begin
                lo_d    = io_data_i;
                state_d = S_HI;
            end else begin
                state_d = S_LO;
            end
        end
        if (pop) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
            if (dec_q == DW'(TOKEN_DECIMATION - 1)) begin
                dec_d   = '0;
                token_d = ~token_q;
            end else begin
                dec_d = dec_q + DW'(1);
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LO;
            lo_q    <= '0;
            dec_q   <= '0;
            token_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            dec_q   <= dec_d;
            token_q <= token_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef LINK_SIPO_ERR_CHK_EN
    logic err_q;
    // Sticky flag: overflow push or yumi against an empty head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else if ((push & full & ~pop) | (core_yumi_i & ~core_valid_o))
            err_q <= 1'b1;
    end
    assign error_o = err_q;
`else
    logic unused_full;
    assign unused_full = full;
    assign error_o     = 1'b0;
`endif

endmodule

// File: tb/tb_link_downstream_sipo.sv
// Self-checking bench for link_downstream_sipo (default parameters).
module tb_link_downstream_sipo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        io_valid_i;
    logic [31:0] io_data_i;
    logic        core_valid_o;
    logic [63:0] core_data_o;
    logic        core_yumi_i;
    logic        io_token_o;
    logic [6:0]  credits_returned_o;
    logic        error_o;

    link_downstream_sipo dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .io_valid_i         (io_valid_i),
        .io_data_i          (io_data_i),
        .core_valid_o       (core_valid_o),
        .core_data_o        (core_data_o),
        .core_yumi_i        (core_yumi_i),
        .io_token_o         (io_token_o),
        .credits_returned_o (credits_returned_o),
        .error_o            (error_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        int          gap;
    } vec_t;

    vec_t        vecs [4];
    logic [63:0] sb [$];
    int          passed = 0;
    int          total  = 0;
    int          exp_cnt;
    int          exp_dec;
    logic        exp_tok;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_reset();
        sb.delete();
        exp_cnt = 0;
        exp_dec = 0;
        exp_tok = 1'b0;
    endtask

    task automatic model_pop();
        exp_cnt = (exp_cnt + 1) % 128;
        if (exp_dec == 3) begin
            exp_dec = 0;
            exp_tok = ~exp_tok;
        end else begin
            exp_dec++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        io_valid_i = 1'b0;
        core_yumi_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge where the word is visible.
    task automatic send_word(input logic [31:0] lo, input logic [31:0] hi, input int gap);
        io_valid_i = 1'b1;
        io_data_i  = lo;
        @(negedge clk);
        io_valid_i = 1'b0;
        for (int g = 0; g < gap; g++) @(negedge clk);
        io_valid_i = 1'b1;
        io_data_i  = hi;
        @(negedge clk);
        io_valid_i = 1'b0;
        sb.push_back({hi, lo});
    endtask

    // Called at a negedge; pops the head and checks it against the scoreboard.
    task automatic pop_chk(input bit check_credits);
        logic [63:0] exp;
        chk("pop_valid", core_valid_o, 1'b1);
        if (sb.size() == 0) begin
            chk("sb_nonempty", 1'b0, 1'b1);
            exp = '0;
        end else begin
            exp = sb.pop_front();
        end
        chk("pop_data", core_data_o, exp);
        core_yumi_i = 1'b1;
        @(negedge clk);
        core_yumi_i = 1'b0;
        model_pop();
        if (check_credits) begin
            chk("token", io_token_o, exp_tok);
            chk("credits", credits_returned_o, 7'(exp_cnt));
        end
    endtask

    initial begin
        vecs[0] = '{32'hCAFE0001, 32'h0BAD0001, 0};
        vecs[1] = '{32'h12345678, 32'h9ABCDEF0, 2};
        vecs[2] = '{32'hFFFFFFFF, 32'h00000000, 1};
        vecs[3] = '{32'h00000000, 32'hFFFFFFFF, 0};

        rst_n = 1'b0;
        io_valid_i = 1'b0;
        io_data_i = '0;
        core_yumi_i = 1'b0;
        model_reset();
        #12;
        chk("rst_valid",   core_valid_o, 1'b0);
        chk("rst_data",    core_data_o, 64'h0);
        chk("rst_token",   io_token_o, 1'b0);
        chk("rst_credits", credits_returned_o, 7'h0);
        chk("rst_error",   error_o, 1'b0);
        do_reset();

        // Back-to-back halves: no valid until the hi half is accepted.
        io_valid_i = 1'b1; io_data_i = 32'h11111111;
        @(negedge clk);
        chk("b2b_pre_valid", core_valid_o, 1'b0);
        io_data_i = 32'h22222222;
        @(negedge clk);
        io_valid_i = 1'b0;
        sb.push_back(64'h22222222_11111111);
        chk("b2b_valid", core_valid_o, 1'b1);
        chk("b2b_data",  core_data_o, 64'h22222222_11111111);
        pop_chk(1);
        chk("b2b_empty", core_valid_o, 1'b0);

        // Gap of three idle cycles between halves.
        io_valid_i = 1'b1; io_data_i = 32'hAAAA0000;
        @(negedge clk);
        io_valid_i = 1'b0;
        for (int g = 0; g < 3; g++) begin
            chk("gap_no_valid", core_valid_o, 1'b0);
            @(negedge clk);
        end
        io_valid_i = 1'b1; io_data_i = 32'h0000BBBB;
        @(negedge clk);
        io_valid_i = 1'b0;
        sb.push_back(64'h0000BBBB_AAAA0000);
        chk("gap_data", core_data_o, 64'h0000BBBB_AAAA0000);
        pop_chk(1);

        // Fill the FIFO from the table, then push a 5th word with a same-cycle pop.
        foreach (vecs[i]) send_word(vecs[i].lo, vecs[i].hi, vecs[i].gap);
        io_valid_i = 1'b1; io_data_i = 32'h55550005;
        @(negedge clk);
        io_data_i = 32'h66660006;
        chk("full_head", core_data_o, sb[0]);
        void'(sb.pop_front());
        core_yumi_i = 1'b1;
        @(negedge clk);
        io_valid_i = 1'b0;
        core_yumi_i = 1'b0;
        model_pop();
        sb.push_back(64'h66660006_55550005);
        chk("full_pp_error", error_o, 1'b0);
        for (int i = 0; i < 4; i++) pop_chk(1);
        chk("full_drained", core_valid_o, 1'b0);

        // Token and credit sequence from a clean reset, then wrap at 128.
        do_reset();
        for (int i = 0; i < 130; i++) begin
            send_word(32'(i), 32'(i) ^ 32'hA5A5A5A5, i % 3);
            pop_chk(i < 12);
            if (i == 3) chk("tok_after4", io_token_o, 1'b1);
            if (i == 7) begin
                chk("tok_after8", io_token_o, 1'b0);
                chk("cred_8", credits_returned_o, 7'd8);
            end
        end
        chk("cred_wrap", credits_returned_o, 7'd2);

        // Reset while holding a lo half: that half must be discarded.
        io_valid_i = 1'b1; io_data_i = 32'hDEADDEAD;
        @(negedge clk);
        io_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid",   core_valid_o, 1'b0);
        chk("midrst_data",    core_data_o, 64'h0);
        chk("midrst_credits", credits_returned_o, 7'h0);
        chk("midrst_token",   io_token_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        send_word(32'h00000001, 32'h00000002, 0);
        chk("midrst_pkt", core_data_o, 64'h00000002_00000001);
        pop_chk(1);

`ifdef LINK_SIPO_ERR_CHK_EN
        // Yumi against an empty FIFO.
        core_yumi_i = 1'b1;
        @(negedge clk);
        core_yumi_i = 1'b0;
        chk("err_yumi", error_o, 1'b1);
        chk("err_yumi_cred", credits_returned_o, 7'(exp_cnt));
        repeat (3) @(negedge clk);
        chk("err_sticky", error_o, 1'b1);
        do_reset();
        chk("err_cleared", error_o, 1'b0);
        // Overflow push with no pop: word dropped.
        foreach (vecs[i]) send_word(vecs[i].lo, vecs[i].hi, 0);
        chk("ovf_pre", error_o, 1'b0);
        io_valid_i = 1'b1; io_data_i = 32'h77777777;
        @(negedge clk);
        io_data_i = 32'h88888888;
        @(negedge clk);
        io_valid_i = 1'b0;
        chk("ovf_err", error_o, 1'b1);
        for (int i = 0; i < 4; i++) pop_chk(1);
        chk("ovf_dropped", core_valid_o, 1'b0);
`else
        // Illegal yumi is ignored entirely.
        core_yumi_i = 1'b1;
        @(negedge clk);
        core_yumi_i = 1'b0;
        chk("noerr_yumi", error_o, 1'b0);
        chk("noerr_cred", credits_returned_o, 7'(exp_cnt));
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/link_downstream_sipo.md
Name: link_downstream_sipo

Overview:
- Receive-side counterpart to the upstream token-in/PISO stage.
- Consumes the two 32-bit half-words per 64-bit packet that the upstream serializer emits on the io channel (data_cycle_0 first, then data_cycle_1).
- Reassembles each pair into a 64-bit core word and buffers it in a small FIFO for the core.
- Returns credits to upstream by toggling io_token_o once every TOKEN_DECIMATION words the core consumes.

Parameters:
- HALF_WIDTH, 32, width of one io-side half-word.
- FIFO_DEPTH, 4, core-word buffer entries; power of two, >=2; equals upstream credit pool size.
- TOKEN_DECIMATION, 4, core words consumed per io_token_o toggle; power of two, >=1, <=FIFO_DEPTH.
- CNT_WIDTH, 7, width of credits_returned_o.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous, active-low reset.
- io_valid_i  in  1  half-word present on io_data_i this cycle.
- io_data_i  in  HALF_WIDTH  incoming half-word; low half first.
- core_valid_o  out  1  FIFO head holds a complete word.
- core_data_o  out  2*HALF_WIDTH  FIFO head, {hi,lo}.
- core_yumi_i  in  1  core consumes head this cycle; legal only when core_valid_o=1.
- io_token_o  out  1  credit-return token; each toggle returns TOKEN_DECIMATION credits.
- credits_returned_o  out  CNT_WIDTH  total words consumed, mod 2^CNT_WIDTH.
- error_o  out  1  sticky protocol-error flag (see Optional Feature).

Behaviour:
- Reset (async assert, sync-released usage assumed by system): assembler in S_LO, lo register 0, FIFO empty, core_valid_o=0, core_data_o=0, io_token_o=0, credits_returned_o=0, error_o=0, decimation counter 0.
- Assembler FSM, two states:
  - S_LO: io_valid_i=1 -> capture io_data_i into lo reg, go S_HI.
  - S_HI: io_valid_i=1 -> push {io_data_i, lo} into FIFO, go S_LO.
  - io_valid_i=0 -> hold state; gaps between halves are legal.
- Latency: the word is visible on core_valid_o/core_data_o the cycle after its hi half is accepted. No combinational path from io_* to core_*.
- FIFO:
  - Registered head output, wrap-around read/write pointers with an extra wrap bit for the full/empty distinction.
  - Pop on core_yumi_i & core_valid_o.
  - Simultaneous push and pop when full: both take effect, occupancy stays FIFO_DEPTH, no overflow.
  - Simultaneous push and pop when empty is impossible, because the head is registered.
- Overflow (push while full with no pop): word dropped, pointers unchanged. Upstream credit protocol makes this unreachable in legal traffic.
- Token generation:
  - Decimation counter increments on each pop.
  - On the pop where the counter equals TOKEN_DECIMATION-1: counter wraps to 0 and io_token_o toggles in the same clock edge (registered).
  - With TOKEN_DECIMATION=1, every pop toggles.
- credits_returned_o increments on each pop and wraps 127->0 (CNT_WIDTH=7). It matches the upstream finish-count observable in formal checks.
- Reset mid-packet: any half-captured lo word and all FIFO contents are discarded; the FSM returns to S_LO.

Optional Feature:
- Macro LINK_SIPO_ERR_CHK_EN.
- Defined: error_o sets and holds until reset on either:
  - a FIFO overflow push;
  - core_yumi_i=1 while core_valid_o=0 (illegal yumi is ignored for state but flagged).
- Not defined:
  - error_o is tied to 0 and the error logic is absent.
  - Illegal yumi is silently ignored.
  - Overflow still drops the word.

Decomposition:
- Shared package link_pkg holds:
  - state enum {S_LO, S_HI};
  - default constants HALF_WIDTH=32, FIFO_DEPTH=4, TOKEN_DECIMATION=4, CNT_WIDTH=7;
  - a function computing pointer width from depth.
- One natural sub-module, link_sipo_fifo: parameterised-width synchronous FIFO with registered head, full/empty and push/pop ports.
- The FSM, decimation counter and token logic stay in the top.

Test Plan:
- Two halves 0x11111111 then 0x22222222 on consecutive cycles -> next cycle core_valid_o=1, core_data_o=0x22222222_11111111.
- Half 0xAAAA0000, 3 idle cycles, half 0x0000BBBB -> single word 0x0000BBBB_AAAA0000, no valid before the hi half.
- 4 words filled with yumi held low -> FIFO full. 5th word pushed in the same cycle as a yumi -> no error, occupancy 4, order preserved.
- 8 words pushed and popped with TOKEN_DECIMATION=4 -> io_token_o toggles 0->1 after the 4th pop and 1->0 after the 8th; credits_returned_o=8.
- 130 pops -> credits_returned_o=2 (wrap). rst_n asserted while in S_HI -> next packet's first half treated as lo; all outputs 0 during reset.
- With LINK_SIPO_ERR_CHK_EN: yumi while empty, or 5th push while full with no pop -> error_o=1 the next cycle, stays 1 until rst_n.
